multicycle_controller: RTL and testbench

Sequencing FSM that lets the RV32I datapath (program counter, instruction memory, register file, immediate extender, SrcB and PCNext muxes) run as a multicycle processor sharing one ALU and one memory port. Each cycle it decodes the latched instruction fields and drives the datapath's mux selects and write strobes. It stretches memory states with a ready handshake and traps on illegal opcodes or memory timeouts. It sits beside the datapath and is the only source of its control signals.

---
 rtl/multicycle_controller.sv | 218 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath sharing one ALU and one memory port.
// Decodes latched instruction fields into mux selects and write strobes, with a memory-ready timeout and sticky trap.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       EN,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [3:0] State,
  output logic       Trap
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] T_MAX = CW'(MEM_TIMEOUT);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t        state_r, state_next_s;
  logic [CW-1:0] count_r, count_next_s;
  logic          trap_r;
  logic          wait_s, run_s;
  logic          pc_write_s, ir_write_s, reg_write_s, mem_write_s;

  function automatic logic f3_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b010, 3'b110, 3'b111: f3_legal = 1'b1;
      default:                        f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic op5, input logic f7b5);
    case (f3)
      3'b000:  alu_decode = (op5 & f7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  // Next-state and timeout-counter logic
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    wait_s       = 1'b0;
    case (state_r)
      S_FETCH: begin
        wait_s = 1'b1;
        if (MemReady)              state_next_s = S_DECODE;
        else if (count_r == T_MAX) state_next_s = S_TRAP;
        else                       state_next_s = state_r;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_R:         state_next_s = f3_legal(funct3) ? S_EXECR : S_TRAP;
          OP_I:         state_next_s = f3_legal(funct3) ? S_EXECI : S_TRAP;
          OP_JAL:       state_next_s = S_JAL;
          OP_BR:        state_next_s = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
          default:      state_next_s = S_TRAP;
        endcase
      end
      S_MEMADR: state_next_s = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        wait_s = 1'b1;
        if (MemReady)              state_next_s = S_MEMWB;
        else if (count_r == T_MAX) state_next_s = S_TRAP;
        else                       state_next_s = state_r;
      end
      S_MEMWRITE: begin
        wait_s = 1'b1;
        if (MemReady)              state_next_s = S_FETCH;
        else if (count_r == T_MAX) state_next_s = S_TRAP;
        else                       state_next_s = state_r;
      end
      S_MEMWB, S_ALUWB, S_BEQ:   state_next_s = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:   state_next_s = S_ALUWB;
      S_TRAP:                    state_next_s = S_TRAP;
      default:                   state_next_s = S_TRAP;
    endcase
    if (state_next_s != state_r)                        count_next_s = {CW{1'b0}};
    else if (wait_s && !MemReady && (count_r < T_MAX))  count_next_s = count_r + CW'(1'b1);
    else                                                count_next_s = count_r;
  end

  // State, counter and sticky trap registers; frozen while EN is low
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= S_FETCH;
      count_r <= {CW{1'b0}};
      trap_r  <= 1'b0;
    end else if (EN) begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      trap_r  <= trap_r | (state_next_s == S_TRAP);
    end else begin
      state_r <= state_r;
      count_r <= count_r;
      trap_r  <= trap_r;
    end
  end

  // Per-state selects and raw strobes
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    mem_write_s = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUControl  = 3'b000;
    case (state_r)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = MemReady;
        pc_write_s = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, op[5], funct7b5);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, op[5], funct7b5);
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_s = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        pc_write_s = Zero;
      end
      default: begin
        pc_write_s = 1'b0;
      end
    endcase
  end

  // Immediate format follows the opcode regardless of state
  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Strobes drop immediately on reset assertion or when stalled
  assign run_s    = EN & RESET;
  assign PCWrite  = pc_write_s  & run_s;
  assign IRWrite  = ir_write_s  & run_s;
  assign RegWrite = reg_write_s & run_s;
  assign MemWrite = mem_write_s & run_s;
  assign State    = state_r;
  assign Trap     = trap_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: behavioural model checked every cycle plus directed literal checks.
module tb_multicycle_controller;
  localparam int MT = 15;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4, S_MEMWRITE = 5;
  localparam int S_EXECR = 6, S_ALUWB = 7, S_EXECI = 8, S_JAL = 9, S_BEQ = 10, S_TRAP = 11;

  logic CLK = 1'b0;
  logic RESET = 1'b0, EN = 1'b0, funct7b5 = 1'b0, Zero = 1'b0, MemReady = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, Trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int n_cmp = 0, n_bad = 0;
  int m_state = 0, m_count = 0;
  bit m_trap = 1'b0;
  logic [20:0] obs;

  multicycle_controller #(.MEM_TIMEOUT(MT)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .State(State), .Trap(Trap)
  );

  always #5 CLK = ~CLK;

  function automatic int alu_op(input logic [2:0] f3);
    if (f3 == 3'd0) return (op[5] && funct7b5) ? 1 : 0;
    if (f3 == 3'd2) return 5;
    if (f3 == 3'd6) return 3;
    if (f3 == 3'd7) return 2;
    return 0;
  endfunction

  function automatic logic [20:0] expected_out();
    int a = 0, b = 0, rs = 0, alu = 0, imm = 0;
    bit pcw = 0, irw = 0, rw = 0, mw = 0, adr = 0;
    case (m_state)
      S_FETCH:    begin b = 2; rs = 2; irw = MemReady; pcw = MemReady; end
      S_DECODE:   begin a = 1; b = 1; end
      S_MEMADR:   begin a = 2; b = 1; end
      S_MEMREAD:  adr = 1;
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_MEMWB:    begin rs = 1; rw = 1; end
      S_EXECR:    begin a = 2; b = 0; alu = alu_op(funct3); end
      S_EXECI:    begin a = 2; b = 1; alu = alu_op(funct3); end
      S_ALUWB:    rw = 1;
      S_JAL:      begin a = 1; b = 2; pcw = 1; end
      S_BEQ:      begin a = 2; b = 0; alu = 1; pcw = Zero; end
      default:    ;
    endcase
    if (op == 7'b0100011) imm = 1;
    else if (op == 7'b1100011) imm = 2;
    else if (op == 7'b1101111) imm = 3;
    if (!(EN && RESET)) begin pcw = 0; irw = 0; rw = 0; mw = 0; end
    return {4'(m_state), m_trap, pcw, irw, rw, mw, adr, 2'(rs), 2'(a), 2'(b), 3'(alu), 2'(imm)};
  endfunction

  function automatic int decode_target();
    bit alu_ok = (funct3 == 3'd0) || (funct3 == 3'd2) || (funct3 == 3'd6) || (funct3 == 3'd7);
    if (op == 7'b0000011 || op == 7'b0100011) return S_MEMADR;
    if (op == 7'b0110011) return alu_ok ? S_EXECR : S_TRAP;
    if (op == 7'b0010011) return alu_ok ? S_EXECI : S_TRAP;
    if (op == 7'b1101111) return S_JAL;
    if (op == 7'b1100011 && funct3 == 3'd0) return S_BEQ;
    return S_TRAP;
  endfunction

  task automatic model_step();
    int nxt = m_state;
    bit waiting = (m_state == S_FETCH) || (m_state == S_MEMREAD) || (m_state == S_MEMWRITE);
    if (!EN || !RESET) return;
    if (waiting) begin
      if (MemReady) nxt = (m_state == S_FETCH) ? S_DECODE : (m_state == S_MEMREAD) ? S_MEMWB : S_FETCH;
      else if (m_count == MT) nxt = S_TRAP;
    end else if (m_state == S_DECODE) nxt = decode_target();
    else if (m_state == S_MEMADR) nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
    else if (m_state == S_MEMWB || m_state == S_ALUWB || m_state == S_BEQ) nxt = S_FETCH;
    else if (m_state == S_EXECR || m_state == S_EXECI || m_state == S_JAL) nxt = S_ALUWB;
    if (nxt != m_state) m_count = 0;
    else if (waiting && !MemReady && m_count < MT) m_count++;
    if (nxt == S_TRAP) m_trap = 1'b1;
    m_state = nxt;
  endtask

  task automatic model_reset();
    m_state = S_FETCH; m_count = 0; m_trap = 1'b0;
  endtask

  task automatic compare();
    logic [20:0] exp_v = expected_out();
    obs = {State, Trap, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc};
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL outputs t=%0t got=%h expected=%h (model state %0d)", $time, obs, exp_v, m_state);
    end
  endtask

  task automatic check_lit(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // One cycle: check outputs after inputs settle, advance model on the clock edge
  task automatic tick();
    #1 compare();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET = 1'b0; EN = 1'b0; MemReady = 1'b1;
    model_reset();
    tick();
    EN = 1'b1;
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    int lw_seq[6] = '{0, 1, 2, 3, 4, 0};
    int mw_cnt, rw_cnt;
    logic [6:0] ops[8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1101111, 7'b1100011, 7'b0110111, 7'b0000000};
    @(negedge CLK);

    // lw with MemReady tied high
    do_reset();
    op = 7'b0000011; funct3 = 3'd2; EN = 1'b1; MemReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_lit($sformatf("lw_state%0d", i), int'(obs[20:17]), lw_seq[i]);
      if (i == 0) check_lit("lw_irwrite", int'(obs[14]), 1);
      if (i == 1) check_lit("lw_pcwrite_decode", int'(obs[15]), 0);
      if (i == 4) begin
        check_lit("lw_regwrite", int'(obs[13]), 1);
        check_lit("lw_resultsrc", int'(obs[10:9]), 1);
      end
    end

    // sw stalled three cycles in MEMWRITE
    do_reset();
    op = 7'b0100011; funct3 = 3'd2; MemReady = 1'b1;
    rw_cnt = 0; mw_cnt = 0;
    repeat (3) begin tick(); rw_cnt += int'(obs[13]); end
    MemReady = 1'b0;
    repeat (3) begin tick(); mw_cnt += int'(obs[12]); rw_cnt += int'(obs[13]); end
    MemReady = 1'b1;
    tick(); mw_cnt += int'(obs[12]); rw_cnt += int'(obs[13]);
    tick();
    check_lit("sw_memwrite_cycles", mw_cnt, 4);
    check_lit("sw_regwrite", rw_cnt, 0);
    check_lit("sw_back_fetch", int'(obs[20:17]), S_FETCH);

    // beq with Zero both ways
    for (int z = 0; z < 2; z++) begin
      do_reset();
      op = 7'b1100011; funct3 = 3'd0; Zero = z[0]; MemReady = 1'b1;
      tick(); tick(); tick();
      check_lit($sformatf("beq_pcwrite_z%0d", z), int'(obs[15]), z);
      check_lit("beq_aluctl", int'(obs[4:2]), 1);
      tick();
      check_lit("beq_back_fetch", int'(obs[20:17]), S_FETCH);
    end

    // R-type sub, addi with funct7b5 set, illegal R funct3
    do_reset();
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b1; MemReady = 1'b1;
    tick(); tick(); tick();
    check_lit("sub_state", int'(obs[20:17]), S_EXECR);
    check_lit("sub_aluctl", int'(obs[4:2]), 1);
    do_reset();
    op = 7'b0010011;
    tick(); tick(); tick();
    check_lit("addi_state", int'(obs[20:17]), S_EXECI);
    check_lit("addi_aluctl", int'(obs[4:2]), 0);
    do_reset();
    op = 7'b0110011; funct3 = 3'd1;
    tick(); tick(); tick();
    check_lit("illegal_state", int'(obs[20:17]), S_TRAP);
    check_lit("illegal_trap", int'(obs[16]), 1);
    tick(); tick();
    check_lit("trap_sticky", int'(obs[16]), 1);

    // Fetch timeout and last-cycle acceptance
    do_reset();
    funct3 = 3'd0; MemReady = 1'b0;
    repeat (15) tick();
    tick();
    check_lit("timeout_pre", int'(obs[20:17]), S_FETCH);
    tick();
    check_lit("timeout_trap", int'(obs[20:17]), S_TRAP);
    do_reset();
    MemReady = 1'b0;
    repeat (15) tick();
    MemReady = 1'b1;
    tick();
    check_lit("late_ready_irwrite", int'(obs[14]), 1);
    tick();
    check_lit("late_ready_decode", int'(obs[20:17]), S_DECODE);

    // Async reset in MEMWB drops RegWrite without a clock
    do_reset();
    op = 7'b0000011; funct3 = 3'd2; MemReady = 1'b1;
    repeat (4) tick();
    #1 compare();
    check_lit("memwb_regwrite", int'(RegWrite), 1);
    #1 RESET = 1'b0;
    #1 check_lit("reset_regwrite", int'(RegWrite), 0);
    check_lit("reset_state", int'(State), S_FETCH);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1; MemReady = 1'b0;
    tick();
    check_lit("after_reset_state", int'(obs[20:17]), S_FETCH);

    // EN low for two cycles in EXECR
    do_reset();
    op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; MemReady = 1'b1;
    tick(); tick();
    EN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_lit("en_hold_state", int'(obs[20:17]), S_EXECR);
      check_lit("en_hold_strobes", int'(obs[15:12]), 0);
    end
    EN = 1'b1;
    tick(); tick();
    check_lit("en_resume", int'(obs[20:17]), S_ALUWB);

    // Randomized episodes against the model
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        if (m_state == S_FETCH) begin
          op = ops[$urandom_range(0, 7)];
          funct3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
          funct7b5 = 1'($urandom_range(0, 1));
        end
        Zero = 1'($urandom_range(0, 1));
        MemReady = ($urandom_range(0, 3) != 0);
        EN = ($urandom_range(0, 7) != 0);
        tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
